// File: rtl/mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// mux_scan_nto1
//
// Parametrised N-to-1, W-bit registered multiplexer. It has a manual select
// mode and an automatic scan mode with a programmable dwell per channel. The
// output register sits behind a valid/ready handshake, so a downstream
// consumer can stall it.
//
// With the default parameters (N=16, W=1, MSB_FIRST=1) it behaves like the
// legacy 16-to-1 bit mux: sel=0 picks the top bit of `in`.
//
// Parameters
//   N         channel count, power of 2, N >= 2
//   W         bits per channel
//   SW        select / pointer width, $clog2(N)
//   DWELL     accepted beats spent on each channel in scan mode, >= 1
//   MSB_FIRST 1: logical k reads physical N-1-k; 0: logical k reads physical k
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         channel data; physical channel p is in[p*W +: W]
//   sel        manual-mode channel, also the start channel on scan entry
//   scan_en    1 = scan mode, 0 = manual mode
//   out        registered channel data
//   out_ch     logical index of the data currently on out
//   out_valid  out holds a beat (1 from the first beat after reset onward)
//   out_ready  downstream accepts the current beat
//   wrap       current beat is the first one after the pointer wrapped to 0
// -----------------------------------------------------------------------------
module mux_scan_nto1 #(
  parameter int N         = 16,
  parameter int W         = 1,
  parameter int SW        = $clog2(N),
  parameter int DWELL     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           scan_en,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           wrap
);

  // Dwell counter wide enough to hold DWELL-1 for any DWELL >= 1.
  localparam int DCW = $clog2(DWELL) + 1;

  localparam logic [SW-1:0]  LAST_CH  = SW'(N - 1);
  localparam logic [DCW-1:0] LAST_BEAT = DCW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  state_e         state_q,     state_d;
  logic [W-1:0]   out_q,       out_d;
  logic [SW-1:0]  out_ch_q,    out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic           wrap_q,      wrap_d;
  logic [SW-1:0]  ptr_q,       ptr_d;
  logic [DCW-1:0] dcnt_q,      dcnt_d;

  // The output register accepts a new beat whenever it is empty or the
  // current beat is being consumed.
  logic adv;
  assign adv = !out_valid_q || out_ready;

  // ---------------------------------------------------------------------------
  // Unpack the flat input bus into physical channels
  // ---------------------------------------------------------------------------
  logic [W-1:0] phys_ch [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign phys_ch[g] = in[g*W +: W];
  end

  // Logical channel chosen for capture this cycle, and its physical slot.
  logic [SW-1:0] cap_k;
  logic [SW-1:0] cap_phys;

  // N is a power of 2, so N-1-k stays inside SW bits.
  assign cap_phys = (MSB_FIRST != 0) ? (LAST_CH - cap_k) : cap_k;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (adv) begin
      // IDLE is left on the first accepted edge; MAN and SCAN follow scan_en.
      state_d = scan_en ? ST_SCAN : ST_MAN;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    wrap_d      = wrap_q;
    ptr_d       = ptr_q;
    dcnt_d      = dcnt_q;
    out_ch_d    = out_ch_q;
    cap_k       = sel;

    if (adv) begin
      out_valid_d = 1'b1;
      wrap_d      = 1'b0;

      unique case (state_d)
        ST_SCAN: begin
          if (state_q != ST_SCAN) begin
            // Entry beat: restart from sel and count it as the first dwell
            // beat. No pointer memory survives a trip through MAN.
            cap_k  = sel;
            ptr_d  = sel;
            dcnt_d = '0;
          end else if (dcnt_q == LAST_BEAT) begin
            // Dwell used up: step the pointer with natural SW-bit wrap and
            // flag the beat that lands on channel 0.
            cap_k  = ptr_q + 1'b1;
            ptr_d  = ptr_q + 1'b1;
            dcnt_d = '0;
            wrap_d = (ptr_q == LAST_CH);
          end else begin
            cap_k  = ptr_q;
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          // Manual beat; ptr and dcnt are left alone.
          cap_k = sel;
        end
      endcase

      out_ch_d = cap_k;
    end
  end

  // Data capture kept out of the block above so the channel decode reads as a
  // single mux driven by cap_phys.
  always_comb begin
    out_d = out_q;
    if (adv) begin
      out_d = phys_ch[cap_phys];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      ptr_q       <= '0;
      dcnt_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_nto1
//
// Directed testbench for mux_scan_nto1. Instance dut_a uses the legacy
// defaults (N=16, W=1, MSB_FIRST=1, DWELL=1); instance dut_b uses N=4, W=8,
// MSB_FIRST=0, DWELL=3 for the dwell / wide-channel case. Outputs are sampled
// 1 time unit after each rising edge; inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_mux_scan_nto1;

  localparam logic [15:0] PAT_A = 16'b1010110110010010;
  localparam logic [31:0] PAT_B = 32'h44332211;

  logic clk;

  // dut_a signals
  logic        rst_n_a;
  logic [15:0] in_a;
  logic [3:0]  sel_a;
  logic        scan_en_a;
  logic        out_ready_a;
  logic [0:0]  out_a;
  logic [3:0]  out_ch_a;
  logic        out_valid_a;
  logic        wrap_a;

  // dut_b signals
  logic        rst_n_b;
  logic [31:0] in_b;
  logic [1:0]  sel_b;
  logic        scan_en_b;
  logic        out_ready_b;
  logic [7:0]  out_b;
  logic [1:0]  out_ch_b;
  logic        out_valid_b;
  logic        wrap_b;

  int checks = 0;
  int errors = 0;

  mux_scan_nto1 dut_a (
    .clk       (clk),
    .rst_n     (rst_n_a),
    .in        (in_a),
    .sel       (sel_a),
    .scan_en   (scan_en_a),
    .out       (out_a),
    .out_ch    (out_ch_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .wrap      (wrap_a)
  );

  mux_scan_nto1 #(
    .N         (4),
    .W         (8),
    .DWELL     (3),
    .MSB_FIRST (0)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .in        (in_b),
    .sel       (sel_b),
    .scan_en   (scan_en_b),
    .out       (out_b),
    .out_ch    (out_ch_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .wrap      (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] ch,
                         input logic o, input logic w, input logic v);
    check({tag, ".out_ch"},    32'(out_ch_a),    32'(ch));
    check({tag, ".out"},       32'(out_a),       32'(o));
    check({tag, ".wrap"},      32'(wrap_a),      32'(w));
    check({tag, ".out_valid"}, 32'(out_valid_a), 32'(v));
  endtask

  task automatic check_b(input string tag, input logic [1:0] ch,
                         input logic [7:0] o, input logic w);
    check({tag, ".out_ch"},    32'(out_ch_b),    32'(ch));
    check({tag, ".out"},       32'(out_b),       32'(o));
    check({tag, ".wrap"},      32'(wrap_b),      32'(w));
    check({tag, ".out_valid"}, 32'(out_valid_b), 32'd1);
  endtask

  initial begin
    // Expected tables for the directed sequences.
    logic [3:0] man_sel  [5] = '{4'd15, 4'd14, 4'd12, 4'd8, 4'd4};
    logic       man_out  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] scan_ch  [6] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
    logic       scan_out [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       scan_wr  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] s6_ch    [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic       s6_out   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] b_ch     [8] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [7:0] b_out    [8] = '{8'h33, 8'h33, 8'h44, 8'h44, 8'h44,
                                 8'h11, 8'h11, 8'h11};
    logic       b_wr     [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0};

    rst_n_a     = 1'b0;
    in_a        = PAT_A;
    sel_a       = 4'd0;
    scan_en_a   = 1'b0;
    out_ready_a = 1'b1;
    rst_n_b     = 1'b0;
    in_b        = PAT_B;
    sel_b       = 2'd2;
    scan_en_b   = 1'b1;
    out_ready_b = 1'b0;

    // 1. Reset and first beat: outputs stay clear across edges in reset.
    #12;
    check_a("t1_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    check({"t1_reset_b", ".out"}, 32'(out_b), 32'd0);
    rst_n_a = 1'b1;
    tick();
    check_a("t1_first", 4'd0, 1'b1, 1'b0, 1'b1);

    // 2. Manual sweep, one cycle latency, wrap never set.
    for (int i = 0; i < 5; i++) begin
      sel_a = man_sel[i];
      tick();
      check_a($sformatf("t2_man%0d", i), man_sel[i], man_out[i], 1'b0, 1'b1);
    end

    // 3. Scan from 14 through the wrap to 3.
    sel_a     = 4'd14;
    scan_en_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_a($sformatf("t3_scan%0d", i), scan_ch[i], scan_out[i], scan_wr[i], 1'b1);
    end

    // 4. Stall for 3 cycles on channel 3 while in and sel change.
    out_ready_a = 1'b0;
    in_a        = 16'hFFFF;
    sel_a       = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("t4_stall%0d", i), 4'd3, 1'b0, 1'b0, 1'b1);
    end
    out_ready_a = 1'b1;
    tick();
    check_a("t4_resume", 4'd4, 1'b1, 1'b0, 1'b1);

    // 6. Five more scan beats, then manual on 9, then async reset.
    in_a = PAT_A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a($sformatf("t6_scan%0d", i), s6_ch[i], s6_out[i], 1'b0, 1'b1);
    end
    scan_en_a = 1'b0;
    sel_a     = 4'd9;
    tick();
    check_a("t6_man0", 4'd9, 1'b0, 1'b0, 1'b1);
    tick();
    check_a("t6_man1", 4'd9, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_a("t6_async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t6_rst_hold", 4'd0, 1'b0, 1'b0, 1'b0);
    sel_a     = 4'd5;
    scan_en_a = 1'b1;
    rst_n_a   = 1'b1;
    tick();
    check_a("t6_restart0", 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    check_a("t6_restart1", 4'd6, 1'b0, 1'b0, 1'b1);

    // 5. Dwell of 3 with 8-bit channels. out_ready starts low: the empty
    // register still takes the entry beat, then the next edge is a stall.
    rst_n_b = 1'b1;
    tick();
    check_b("t5_entry", 2'd2, 8'h33, 1'b0);
    in_b = 32'hAABBCCDD;
    tick();
    check_b("t5_stall", 2'd2, 8'h33, 1'b0);
    in_b        = PAT_B;
    out_ready_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_b($sformatf("t5_beat%0d", i), b_ch[i], b_out[i], b_wr[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_nto1.md
# mux_scan_nto1

Parametrised N-to-1, W-bit registered multiplexer. It is the sequential successor to the combinational 16-to-1 bit mux. It supports manual select and automatic channel scanning, with a programmable dwell per channel. The output register uses a valid/ready handshake, so a downstream sampler or serialiser can stall it. The default parameters reproduce the legacy 16-to-1 mapping: `sel=0` selects the top bit.

## Interface

Parameters:
- `N`, 16: channel count. Must be a power of 2, with N ≥ 2.
- `W`, 1: width of each channel in bits.
- `SW`, $clog2(N): width of the select and pointer.
- `DWELL`, 1: accepted beats per channel in scan mode. Must be ≥ 1.
- `MSB_FIRST`, 1: channel mapping.
  - When 1, logical index k reads physical channel N-1-k (legacy mapping).
  - When 0, logical index k reads physical channel k.

Ports:
- `clk`, input, 1: the single clock. Rising edge.
- `rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `in`, input, N*W: channel data. Physical channel p is `in[p*W +: W]`.
- `sel`, input, SW: logical channel in manual mode. Start channel on scan entry.
- `scan_en`, input, 1: 1 selects scan mode, 0 selects manual mode.
- `out`, output, W: registered channel data.
- `out_ch`, output, SW: logical index of the data currently on `out`.
- `out_valid`, output, 1: `out` holds a beat.
- `out_ready`, input, 1: downstream accepts the beat.
- `wrap`, output, 1: this beat is the first beat after the pointer wrapped from N-1 to 0.

## Operation

- Reset clears everything immediately, without waiting for a clock edge:
  - state = IDLE
  - `out` = 0, `out_ch` = 0, `out_valid` = 0, `wrap` = 0
  - `ptr` = 0, `dcnt` = 0
- Advance condition: `adv = !out_valid || out_ready`.
  - All registers update only on edges where `adv` = 1.
  - `scan_en`, `sel` and `in` are sampled only on `adv` edges.
  - While stalled, `in` and `sel` changes are ignored.
- `out_valid` goes to 1 on the first `adv` edge after reset release. It stays 1 until the next reset, because the source is always available.
- States:
  - IDLE: entered only by reset.
  - MAN: manual mode.
  - SCAN: scan mode.
- Transitions, evaluated on `adv` edges:
  - IDLE or SCAN → MAN when `scan_en` = 0.
  - IDLE or MAN → SCAN when `scan_en` = 1.
  - MAN → MAN and SCAN → SCAN otherwise.
- MAN beat:
  - capture channel `sel`; `out_ch` ← `sel`; `wrap` ← 0.
  - `ptr` and `dcnt` are unchanged.
- SCAN entry beat (from IDLE or MAN):
  - capture channel `sel`; `ptr` ← `sel`; `dcnt` ← 0; `wrap` ← 0.
  - The entry beat counts as the first dwell beat.
- SCAN beat when `dcnt` < DWELL-1:
  - capture channel `ptr`; `dcnt` ← `dcnt`+1; `wrap` ← 0.
- SCAN beat when `dcnt` = DWELL-1:
  - `ptr` ← `ptr`+1, modulo N (natural SW-bit wrap).
  - `dcnt` ← 0.
  - capture channel `ptr`+1.
  - `wrap` ← (`ptr` == N-1).
- "Capture channel k" means: `out` ← `in` of physical channel (MSB_FIRST ? N-1-k : k); `out_ch` ← k.
- `dcnt` is sized $clog2(DWELL)+1 bits. With DWELL = 1, every SCAN beat advances the pointer.
- Re-entering SCAN after MAN always restarts from `sel`. There is no pointer memory.

## Timing

- Latency is 1 cycle from the `in`/`sel` sampling edge to `out`. There is no combinational path from inputs to outputs.
- With `out_ready` = 1, throughput is one beat per cycle.
- A stall holds `out`, `out_ch`, `out_valid`, `wrap`, `ptr`, `dcnt` and the state constant.
- `out_ready` only gates the next update. It has no combinational effect on any output.
- `wrap` is high for exactly one accepted beat, aligned with `out_ch` = 0.
- If `rst_n` asserts mid-scan or mid-stall, outputs clear in the same cycle.
- After `rst_n` deasserts, the first `adv` edge produces a fresh entry beat.

## Test plan

Unless stated otherwise, tests use N=16, W=1, MSB_FIRST=1, DWELL=1 and `in`=16'b1010110110010010.

1. Reset and first beat.
   - Stimulus: hold `rst_n`=0, then release with `sel`=0, `scan_en`=0, `out_ready`=1.
   - Required: all outputs 0 during reset. One edge after release: `out_valid`=1, `out`=1 (`in[15]`), `out_ch`=0.
2. Manual sweep.
   - Stimulus: `sel` = 15, 14, 12, 8, 4 on successive cycles.
   - Required: `out` = 0, 1, 0, 1, 1, each one cycle late. `wrap` stays 0.
3. Scan with wrap.
   - Stimulus: `sel`=14, `scan_en`=1.
   - Required: `out_ch` = 14, 15, 0, 1 and `out` = 1, 0, 1, 0. `wrap`=1 only on the `out_ch`=0 beat.
4. Stall mid-scan.
   - Stimulus: drop `out_ready` for 3 cycles while `out_ch`=3, and change `in` to 16'hFFFF during the stall.
   - Required: `out`, `out_ch`, `wrap` hold. After `out_ready` returns, `out_ch`=4 on the next edge and `out`=1.
5. Dwell with wide channels.
   - Stimulus: N=4, W=8, MSB_FIRST=0, DWELL=3, `in`=32'h44332211, `sel`=2, scan.
   - Required: `out` = 8'h33 ×3, 8'h44 ×3, 8'h11 ×3. `wrap`=1 on the first 8'h11 beat only.
6. Mode switch and asynchronous reset.
   - Stimulus: scan for 5 beats, set `scan_en`=0 with `sel`=9, then assert `rst_n` between clock edges.
   - Required: the next beat has `out_ch`=9. On reset, outputs are 0 before the next edge. After release, the first beat restarts from `sel`.
